// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decode-side fields, hazard controls and execute-side
// registered fields. The driver of the decode slot uses the master modport,
// the pipeline register uses the slave modport.
//
// Valid semantics: ValidD=1 means the decode slot holds a real instruction in
// this cycle. ValidE=1 means the E stage holds one. There is no ready signal.
// Back-pressure comes only from stall_e, and squashing comes only from flush_e.
interface id_ex_stage_reg_if #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 3
);
  logic                 stall_e;
  logic                 flush_e;

  logic                 ValidD;
  logic                 RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]           ResultSrcD;
  logic [ALUCTRL_W-1:0] ALUControlD;
  logic [XLEN-1:0]      RD1, RD2, ImmExtD, PCPlus4D;
  logic [REG_AW-1:0]    Rs1D, Rs2D, RdD;

  logic                 ValidE;
  logic                 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]           ResultSrcE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic [XLEN-1:0]      RD1E, RD2E, ImmExtE, PCPlus4E;
  logic [REG_AW-1:0]    Rs1E, Rs2E, RdE;

  modport master (
    output stall_e, flush_e, ValidD, RegWriteD, MemWriteD, JumpD, BranchD,
           ALUSrcD, ResultSrcD, ALUControlD, RD1, RD2, ImmExtD, PCPlus4D,
           Rs1D, Rs2D, RdD,
    input  ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE, RD1E, RD2E, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE
  );

  modport slave (
    input  stall_e, flush_e, ValidD, RegWriteD, MemWriteD, JumpD, BranchD,
           ALUSrcD, ResultSrcD, ALUControlD, RD1, RD2, ImmExtD, PCPlus4D,
           Rs1D, Rs2D, RdD,
    output ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE, RD1E, RD2E, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with a stage valid bit, stall (hold) and flush
// (bubble insert). Priority on each edge: reset > flush > stall > load.
// A bubble is all-zero, including data and register addresses, so it can
// never look like a writer of x0 to the forwarding logic.
// Optional macro ID_EX_PERF_CNT_EN adds saturating stall/flush/bubble counters.
module id_ex_stage_reg #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_stage_reg_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic                 memwrite;
    logic                 jump;
    logic                 branch;
    logic                 alusrc;
    logic [1:0]           resultsrc;
    logic [ALUCTRL_W-1:0] aluctrl;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc4;
    logic [REG_AW-1:0]    rs1;
    logic [REG_AW-1:0]    rs2;
    logic [REG_AW-1:0]    rd;
  } e_stage_t;

  e_stage_t e_q;
  e_stage_t e_d;
  e_stage_t d_rec;

  // Next E contents: flush or an invalid decode slot latches a bubble, and a
  // stall keeps the current contents.
  always_comb begin
    d_rec = '{valid:     1'b1,
              regwrite:  bus.RegWriteD,
              memwrite:  bus.MemWriteD,
              jump:      bus.JumpD,
              branch:    bus.BranchD,
              alusrc:    bus.ALUSrcD,
              resultsrc: bus.ResultSrcD,
              aluctrl:   bus.ALUControlD,
              rd1:       bus.RD1,
              rd2:       bus.RD2,
              imm:       bus.ImmExtD,
              pc4:       bus.PCPlus4D,
              rs1:       bus.Rs1D,
              rs2:       bus.Rs2D,
              rd:        bus.RdD};
    e_d = e_q;
    if (bus.flush_e) begin
      e_d = '0;
    end else if (!bus.stall_e) begin
      e_d = bus.ValidD ? d_rec : '0;
    end
  end

  // E-stage register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  assign bus.ValidE      = e_q.valid;
  assign bus.RegWriteE   = e_q.regwrite;
  assign bus.MemWriteE   = e_q.memwrite;
  assign bus.JumpE       = e_q.jump;
  assign bus.BranchE     = e_q.branch;
  assign bus.ALUSrcE     = e_q.alusrc;
  assign bus.ResultSrcE  = e_q.resultsrc;
  assign bus.ALUControlE = e_q.aluctrl;
  assign bus.RD1E        = e_q.rd1;
  assign bus.RD2E        = e_q.rd2;
  assign bus.ImmExtE     = e_q.imm;
  assign bus.PCPlus4E    = e_q.pc4;
  assign bus.Rs1E        = e_q.rs1;
  assign bus.Rs2E        = e_q.rs2;
  assign bus.RdE         = e_q.rd;

`ifdef ID_EX_PERF_CNT_EN
  logic inc_stall;
  logic inc_flush;
  logic inc_bubble;

  // The three events are mutually exclusive, so at most one counter moves.
  assign inc_flush  = bus.flush_e;
  assign inc_stall  = bus.stall_e & ~bus.flush_e;
  assign inc_bubble = ~bus.stall_e & ~bus.flush_e & ~bus.ValidD;

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (inc_stall && (stall_cnt != '1))   stall_cnt  <= stall_cnt + 1'b1;
      if (inc_flush && (flush_cnt != '1))   flush_cnt  <= flush_cnt + 1'b1;
      if (inc_bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule
